column_flattener: RTL and testbench
===================================

COLUMN_FLATTENER -- requirements
Module: column_flattener

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320, columns per frame.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 180, rows per frame.
REQ-003 SHALL have parameter CEIL_COLOR, default 16'h0000, RGB565 ceiling colour.
REQ-004 SHALL have parameter FLOOR_COLOR, default 16'h4208, RGB565 floor colour.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have pixel_clk_in  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have rst_in  input  1  asynchronous active-low reset.
REQ-008 SHALL have col_valid_in  input  1  a column descriptor is offered.
REQ-009 SHALL have col_ready_out  output  1  the block can accept a descriptor.
REQ-010 SHALL have col_index_in  input  9  screen column, 0..SCREEN_WIDTH-1.
REQ-011 SHALL have wall_height_in  input  8  wall slice height in rows.
REQ-012 SHALL have wall_color_in  input  16  RGB565 wall colour.
REQ-013 SHALL have col_last_in  input  1  this is the final column of the frame.
REQ-014 SHALL have ray_valid_out  output  1  pixel and address are valid this cycle.
REQ-015 SHALL have ray_address_out  output  16  framebuffer address, col + SCREEN_WIDTH*row.
REQ-016 SHALL have ray_pixel_out  output  16  RGB565 pixel.
REQ-017 SHALL have ray_last_pixel_out  output  1  one-cycle pulse on the final pixel of the frame.

Function
REQ-018 SHALL have two states, IDLE and DRAW; col_ready_out SHALL be 1 exactly when in IDLE.
REQ-019 SHALL accept a descriptor on a rising edge where col_valid_in and col_ready_out are both 1, and SHALL register all descriptor fields at that edge.
REQ-020 SHALL clamp a captured height above SCREEN_HEIGHT to SCREEN_HEIGHT.
REQ-021 SHALL compute top = (SCREEN_HEIGHT - h) >> 1 (floor) and bottom = top + h, where h is the clamped height.
REQ-022 On acceptance of an in-range column, SHALL enter DRAW and emit one pixel per cycle for rows 0..SCREEN_HEIGHT-1 in ascending order, with no gaps.
REQ-023 Row r SHALL be coloured CEIL_COLOR if r < top, wall_color if top <= r < bottom, and FLOOR_COLOR otherwise.
REQ-024 SHALL register all outputs; for acceptance at edge N, row 0 SHALL be valid in the cycle following edge N, and row 179 in the 180th cycle.
REQ-025 SHALL generate the address incrementally: col at row 0, then +SCREEN_WIDTH per row, with no multiplier; the maximum value 57599 SHALL fit in 16 bits.
REQ-026 SHALL return to IDLE on the edge that registers the last row, so col_ready_out is 1 while the last row is presented.
REQ-027 A descriptor accepted during that last-row cycle SHALL start its row 0 in the very next cycle, sustaining one column per 180 cycles.
REQ-028 ray_last_pixel_out SHALL be 1 only with the last row of a column captured with col_last_in=1, and only for that one cycle.
REQ-029 A descriptor with col_index_in >= SCREEN_WIDTH SHALL be accepted and discarded: no pixels emitted, state stays IDLE, and no last pulse even if col_last_in=1.
REQ-030 SHALL hold ray_valid_out, ray_pixel_out, ray_address_out and ray_last_pixel_out at 0 while idle.
REQ-031 Input changes during DRAW SHALL be ignored.

Reset
REQ-032 SHALL, with rst_in=0, immediately (asynchronously) force IDLE, and force all outputs to 0 except col_ready_out, which SHALL be 1.
REQ-033 A reset asserted mid-column SHALL abandon that column with no ray_last_pixel_out; operation SHALL resume with the first descriptor accepted after rst_in returns to 1.

Verification
REQ-034 SHALL cover: col 0, h=180, colour F800, last=0 -> 180 valid pixels all F800 at addresses 0,320,...,57280; ray_last_pixel_out stays 0.
REQ-035 SHALL cover: col 5, h=60 -> rows 0-59 CEIL_COLOR, rows 60-119 wall, rows 120-179 FLOOR_COLOR; addresses 5+320r.
REQ-036 SHALL cover: col 319, h=255, last=1 -> clamped to all wall; final address 57599 with ray_last_pixel_out high for exactly that cycle.
REQ-037 SHALL cover: h=0 gives rows 0-89 ceiling and rows 90-179 floor; h=1 gives only row 89 as wall.
REQ-038 SHALL cover: two descriptors held valid back-to-back -> second accepted 180 cycles after first, with ray_valid_out continuously 1 for 360 cycles; col_index 320 with last=1 -> accepted, no output, no last pulse.
REQ-039 SHALL cover: rst_in=0 asserted at row 50 -> outputs 0 without waiting for a clock edge, col_ready_out 1, no last pulse; a new column after release starts at row 0.

Source files
------------

// File: rtl/column_flattener.sv
// Purpose : expands one column descriptor (index, wall height, colour) into a full
//           column of RGB565 pixels: ceiling above the wall slice, floor below it.
// Latency : row 0 is presented the cycle after acceptance; one row per cycle, no gaps.
// Backpr. : col_ready_out is high only when idle (including the last-row cycle);
//           the pixel stream has no ready and cannot be stalled.
//
// Ports:
//   pixel_clk_in        clock, rising edge
//   rst_in              asynchronous active-low reset
//   col_valid_in/col_ready_out   descriptor handshake
//   col_index_in, wall_height_in, wall_color_in, col_last_in   descriptor fields
//   ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out   pixel stream
module column_flattener #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEIL_COLOR    = 16'h0000,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        col_valid_in,
    output logic        col_ready_out,
    input  logic [8:0]  col_index_in,
    input  logic [7:0]  wall_height_in,
    input  logic [15:0] wall_color_in,
    input  logic        col_last_in,
    output logic        ray_valid_out,
    output logic [15:0] ray_address_out,
    output logic [15:0] ray_pixel_out,
    output logic        ray_last_pixel_out
);

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Per-column context captured at acceptance; row arithmetic is done in 16 bits
    // so the comparisons stay width-matched for any screen size.
    typedef struct packed {
        logic [15:0] top;
        logic [15:0] bottom;
        logic [15:0] color;
        logic        last;
    } col_ctx_t;

    localparam logic [15:0] SW       = 16'(SCREEN_WIDTH);
    localparam logic [15:0] SH       = 16'(SCREEN_HEIGHT);
    localparam logic [15:0] LAST_ROW = 16'(SCREEN_HEIGHT - 1);

    function automatic logic [15:0] shade(input logic [15:0] row,
                                          input logic [15:0] top,
                                          input logic [15:0] bottom,
                                          input logic [15:0] wall);
        if (row < top)
            return CEIL_COLOR;
        else if (row < bottom)
            return wall;
        else
            return FLOOR_COLOR;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] row_q, row_d;          // row to present on the next edge
    col_ctx_t    ctx_q, ctx_d;

    logic        vld_d;
    logic [15:0] addr_d;
    logic [15:0] pix_d;
    logic        last_d;

    logic        accept;
    logic        in_range;
    logic [15:0] h_ext;
    logic [15:0] h_clamp;
    logic [15:0] top_in;
    logic [15:0] bottom_in;

    assign col_ready_out = (state_q == IDLE);

    always_comb begin
        accept    = col_valid_in && (state_q == IDLE);
        in_range  = ({7'b0, col_index_in} < SW);
        h_ext     = {8'b0, wall_height_in};
        h_clamp   = (h_ext > SH) ? SH : h_ext;
        top_in    = (SH - h_clamp) >> 1;
        bottom_in = top_in + h_clamp;

        state_d = state_q;
        row_d   = row_q;
        ctx_d   = ctx_q;
        vld_d   = 1'b0;
        addr_d  = 16'h0000;
        pix_d   = 16'h0000;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Out-of-range descriptors are consumed by the handshake and dropped.
                if (accept && in_range) begin
                    state_d = DRAW;
                    ctx_d   = '{top: top_in, bottom: bottom_in,
                                color: wall_color_in, last: col_last_in};
                    row_d   = 16'd1;
                    // Row 0 is produced straight from the inputs so it appears
                    // the cycle right after acceptance.
                    vld_d   = 1'b1;
                    addr_d  = {7'b0, col_index_in};
                    pix_d   = shade(16'd0, top_in, bottom_in, wall_color_in);
                end
            end
            DRAW: begin
                vld_d  = 1'b1;
                // Address walks down the column by one screen row per cycle.
                addr_d = ray_address_out + SW;
                pix_d  = shade(row_q, ctx_q.top, ctx_q.bottom, ctx_q.color);
                if (row_q == LAST_ROW) begin
                    // Leave DRAW as the last row is registered so the next
                    // descriptor can be taken during the last-row cycle.
                    last_d  = ctx_q.last;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q            <= IDLE;
            row_q              <= 16'h0000;
            ctx_q              <= '0;
            ray_valid_out      <= 1'b0;
            ray_address_out    <= 16'h0000;
            ray_pixel_out      <= 16'h0000;
            ray_last_pixel_out <= 1'b0;
        end else begin
            state_q            <= state_d;
            row_q              <= row_d;
            ctx_q              <= ctx_d;
            ray_valid_out      <= vld_d;
            ray_address_out    <= addr_d;
            ray_pixel_out      <= pix_d;
            ray_last_pixel_out <= last_d;
        end
    end

endmodule

// File: tb/tb_column_flattener.sv
// Purpose : self-checking bench for column_flattener against a row/colour model.
// Latency : expects row 0 one cycle after acceptance, 180 rows back to back.
// Backpr. : drives the descriptor handshake only; pixel stream is free-running.
module tb_column_flattener;

    localparam int          W     = 320;
    localparam int          H     = 180;
    localparam logic [15:0] CEIL  = 16'h0000;
    localparam logic [15:0] FLOOR = 16'h4208;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        col_valid_in = 1'b0;
    logic        col_ready_out;
    logic [8:0]  col_index_in = '0;
    logic [7:0]  wall_height_in = '0;
    logic [15:0] wall_color_in = '0;
    logic        col_last_in = 1'b0;
    logic        ray_valid_out;
    logic [15:0] ray_address_out;
    logic [15:0] ray_pixel_out;
    logic        ray_last_pixel_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int col;
        int h;
        int color;
        bit last;
    } desc_t;

    column_flattener #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .CEIL_COLOR   (CEIL),
        .FLOOR_COLOR  (FLOOR)
    ) dut (
        .pixel_clk_in      (pixel_clk_in),
        .rst_in            (rst_in),
        .col_valid_in      (col_valid_in),
        .col_ready_out     (col_ready_out),
        .col_index_in      (col_index_in),
        .wall_height_in    (wall_height_in),
        .wall_color_in     (wall_color_in),
        .col_last_in       (col_last_in),
        .ray_valid_out     (ray_valid_out),
        .ray_address_out   (ray_address_out),
        .ray_pixel_out     (ray_pixel_out),
        .ray_last_pixel_out(ray_last_pixel_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    // Reference model: the wall slice is centred with the odd row going to the floor.
    function automatic logic [15:0] exp_pix(input int h, input int color, input int row);
        int hc;
        int top;
        hc  = (h > H) ? H : h;
        top = (H - hc) / 2;
        if (row < top)           return CEIL;
        else if (row < top + hc) return 16'(color);
        else                     return FLOOR;
    endfunction

    function automatic logic [15:0] exp_addr(input int col, input int row);
        return 16'(col + W * row);
    endfunction

    task automatic drive_desc(input desc_t d);
        col_index_in   = 9'(d.col);
        wall_height_in = 8'(d.h);
        wall_color_in  = 16'(d.color);
        col_last_in    = d.last;
        col_valid_in   = 1'b1;
    endtask

    task automatic drive_garbage();
        col_valid_in   = 1'($urandom_range(0, 1));
        col_index_in   = 9'($urandom);
        wall_height_in = 8'($urandom);
        wall_color_in  = 16'($urandom);
        col_last_in    = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out} !== {33'b0, 1'b1})
            $display("FAIL reset_state got v=%b a=%0d p=%h l=%b rdy=%b, want zeros rdy=1",
                     ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out);
        repeat (3) @(negedge pixel_clk_in);
        rst_in = 1'b1;
        repeat (2) begin
            @(negedge pixel_clk_in);
            checks++;
            if ({ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out} !== {33'b0, 1'b1}) begin
                errors++;
                $display("FAIL idle_after_reset got v=%b a=%0d p=%h l=%b rdy=%b, want zeros rdy=1",
                         ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out);
            end
        end
    endtask

    task automatic test_columns();
        desc_t tbl[$];
        tbl.push_back('{0, 180, 'hF800, 1'b0});
        tbl.push_back('{5, 60, 'h07E0, 1'b0});
        tbl.push_back('{319, 255, 'h001F, 1'b1});
        tbl.push_back('{17, 0, 'hFFFF, 1'b0});
        tbl.push_back('{200, 1, 'hABCD, 1'b1});
        repeat (6)
            tbl.push_back('{$urandom_range(0, W - 1), $urandom_range(0, 255),
                            $urandom_range(0, 65535), 1'($urandom_range(0, 1))});
        foreach (tbl[i]) begin
            @(negedge pixel_clk_in);
            checks++;
            if (col_ready_out !== 1'b1) begin
                errors++;
                $display("FAIL col_ready_idle got %b want 1", col_ready_out);
            end
            drive_desc(tbl[i]);
            for (int r = 0; r < H; r++) begin
                logic [33:0] got;
                logic [33:0] want;
                @(negedge pixel_clk_in);
                got  = {ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out};
                want = {1'b1, exp_addr(tbl[i].col, r), exp_pix(tbl[i].h, tbl[i].color, r),
                        (tbl[i].last && r == H - 1)};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL col_row c=%0d h=%0d r=%0d got v=%b a=%0d p=%h l=%b want v=1 a=%0d p=%h l=%b",
                             tbl[i].col, tbl[i].h, r, got[33], got[32:17], got[16:1], got[0],
                             want[32:17], want[16:1], want[0]);
                end
                checks++;
                if (col_ready_out !== (r == H - 1)) begin
                    errors++;
                    $display("FAIL col_ready_draw r=%0d got %b want %b", r, col_ready_out, (r == H - 1));
                end
                // Inputs wiggle during DRAW and must be ignored; valid drops before the
                // last-row cycle so nothing is accepted there.
                if (r < H - 2) drive_garbage();
                else           col_valid_in = 1'b0;
            end
            @(negedge pixel_clk_in);
            checks++;
            if ({ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out} !== 34'b0) begin
                errors++;
                $display("FAIL idle_outputs got v=%b a=%0d p=%h l=%b want zeros",
                         ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        desc_t a;
        desc_t b;
        a = '{$urandom_range(0, W - 1), $urandom_range(0, 255), $urandom_range(0, 65535), 1'b0};
        b = '{$urandom_range(0, W - 1), $urandom_range(0, 255), $urandom_range(0, 65535), 1'b1};
        @(negedge pixel_clk_in);
        drive_desc(a);
        for (int i = 0; i <= 2 * H; i++) begin
            logic [33:0] got;
            logic [33:0] want;
            @(negedge pixel_clk_in);
            got = {ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out};
            if (i < H)
                want = {1'b1, exp_addr(a.col, i), exp_pix(a.h, a.color, i), 1'b0};
            else if (i < 2 * H)
                want = {1'b1, exp_addr(b.col, i - H), exp_pix(b.h, b.color, i - H), (i == 2 * H - 1)};
            else
                want = 34'b0;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b_row i=%0d got v=%b a=%0d p=%h l=%b want v=%b a=%0d p=%h l=%b",
                         i, got[33], got[32:17], got[16:1], got[0],
                         want[33], want[32:17], want[16:1], want[0]);
            end
            if (i == H - 1 || i == H) begin
                checks++;
                if (col_ready_out !== (i == H - 1)) begin
                    errors++;
                    $display("FAIL b2b_ready i=%0d got %b want %b", i, col_ready_out, (i == H - 1));
                end
            end
            if (i == 0) drive_desc(b);          // held valid until accepted
            if (i == H) col_valid_in = 1'b0;    // b's row 0 visible -> b was taken
        end
    endtask

    task automatic test_out_of_range();
        int cols[2];
        cols[0] = W;
        cols[1] = $urandom_range(W + 1, 511);
        foreach (cols[k]) begin
            @(negedge pixel_clk_in);
            drive_desc('{cols[k], $urandom_range(0, 255), $urandom_range(0, 65535), 1'b1});
            for (int c = 0; c < 6; c++) begin
                @(negedge pixel_clk_in);
                col_valid_in = 1'b0;
                checks++;
                if ({ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out} !== {33'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL oob_discard col=%0d c=%0d got v=%b a=%0d p=%h l=%b rdy=%b want zeros rdy=1",
                             cols[k], c, ray_valid_out, ray_address_out, ray_pixel_out,
                             ray_last_pixel_out, col_ready_out);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        desc_t d;
        desc_t n;
        d = '{$urandom_range(0, W - 1), $urandom_range(0, 255), $urandom_range(0, 65535), 1'b1};
        n = '{$urandom_range(0, W - 1), $urandom_range(0, 255), $urandom_range(0, 65535), 1'b1};
        @(negedge pixel_clk_in);
        drive_desc(d);
        for (int r = 0; r <= 50; r++) begin
            @(negedge pixel_clk_in);
            col_valid_in = 1'b0;
        end
        checks++;
        if (ray_address_out !== exp_addr(d.col, 50)) begin
            errors++;
            $display("FAIL mid_reset_row50 got a=%0d want %0d", ray_address_out, exp_addr(d.col, 50));
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out} !== {33'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got v=%b a=%0d p=%h l=%b rdy=%b want zeros rdy=1",
                     ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out, col_ready_out);
        end
        repeat (3) @(negedge pixel_clk_in);
        rst_in = 1'b1;
        for (int c = 0; c < H; c++) begin
            @(negedge pixel_clk_in);
            checks++;
            if ({ray_valid_out, ray_last_pixel_out} !== 2'b00) begin
                errors++;
                $display("FAIL abandoned_col c=%0d got v=%b l=%b want 0 0", c, ray_valid_out, ray_last_pixel_out);
            end
        end
        drive_desc(n);
        for (int r = 0; r < H; r++) begin
            logic [33:0] got;
            logic [33:0] want;
            @(negedge pixel_clk_in);
            col_valid_in = 1'b0;
            got  = {ray_valid_out, ray_address_out, ray_pixel_out, ray_last_pixel_out};
            want = {1'b1, exp_addr(n.col, r), exp_pix(n.h, n.color, r), (r == H - 1)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL post_reset_row r=%0d got v=%b a=%0d p=%h l=%b want v=1 a=%0d p=%h l=%b",
                         r, got[33], got[32:17], got[16:1], got[0], want[32:17], want[16:1], want[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_columns();
        test_back_to_back();
        test_out_of_range();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
